// File: rtl/hamming_scrub_ctrl.sv
// hamming_scrub_ctrl: background ECC scrubber walking addresses 0..DEPTH-1 through a Hamming decoder.
// Optional corrected-word write-back is enabled by defining HAMMING_SCRUB_WRITEBACK_EN.
module hamming_dec #(
    parameter int DW = 8,
    parameter int PW = 4
) (
    input  logic [DW-1:0] i_data,
    input  logic [PW-1:0] i_par,
    output logic [PW-1:0] o_err_pos,
    output logic [DW-1:0] o_data
);
    // Data bits fill the non-power-of-two codeword positions in ascending order.
    function automatic int dpos(input int d);
        int n;
        int r;
        n = 0;
        r = 0;
        for (int p = 3; p <= DW + PW; p++)
            if ((p & (p - 1)) != 0) begin
                if (n == d) r = p;
                n++;
            end
        return r;
    endfunction

    // Parity bit k sits at position 2^k, so it contributes exactly bit k of the syndrome.
    always_comb begin
        o_err_pos = i_par;
        for (int d = 0; d < DW; d++)
            if (i_data[d]) o_err_pos = o_err_pos ^ PW'(dpos(d));
    end

    always_comb begin
        o_data = i_data;
        for (int d = 0; d < DW; d++)
            if (o_err_pos == PW'(dpos(d))) o_data[d] = ~i_data[d];
    end
endmodule

module hamming_scrub_ctrl #(
    parameter int DW    = 8,
    parameter int PW    = 4,
    parameter int AW    = 8,
    parameter int DEPTH = 256,
    parameter int CW    = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_abort,
    output logic          o_mem_req,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    output logic [PW-1:0] o_mem_wpar,
    input  logic          i_mem_gnt,
    input  logic          i_mem_rvalid,
    input  logic [DW-1:0] i_mem_rdata,
    input  logic [PW-1:0] i_mem_rpar,
    output logic          o_busy,
    output logic          o_done,
    output logic [CW-1:0] o_corr_cnt,
    output logic [CW-1:0] o_uncorr_cnt,
    output logic [AW-1:0] o_last_err_addr
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, CHECK, WR_REQ, NEXT, DONE} state_t;

    state_t        state_q;
    logic [AW-1:0] addr_q, last_q;
    logic [DW-1:0] rdata_q, dec_data;
    logic [PW-1:0] rpar_q, syn;
    logic [CW-1:0] corr_q, uncorr_q, corr_cnt_d, uncorr_cnt_d;
    logic          req_q, busy_q, done_q, abort_q;
    logic          is_corr_d, is_uncorr_d;

    hamming_dec #(.DW(DW), .PW(PW)) u_dec (
        .i_data   (rdata_q),
        .i_par    (rpar_q),
        .o_err_pos(syn),
        .o_data   (dec_data)
    );

    assign is_uncorr_d  = 32'(syn) > DW + PW;
    assign is_corr_d    = (syn != '0) && !is_uncorr_d;
    assign corr_cnt_d   = corr_q + CW'(corr_q != '1);
    assign uncorr_cnt_d = uncorr_q + CW'(uncorr_q != '1);

    assign o_mem_req       = req_q;
    assign o_mem_addr      = addr_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_corr_cnt      = corr_q;
    assign o_uncorr_cnt    = uncorr_q;
    assign o_last_err_addr = last_q;

`ifdef HAMMING_SCRUB_WRITEBACK_EN
    logic          we_q;
    logic [DW-1:0] wdata_q;
    logic [PW-1:0] wpar_q;
    logic [PW-1:0] par_fix_d;
    // A power-of-two syndrome names the flipped parity bit directly.
    assign par_fix_d   = ((syn & (syn - PW'(1))) == '0) ? syn : '0;
    assign o_mem_we    = we_q;
    assign o_mem_wdata = wdata_q;
    assign o_mem_wpar  = wpar_q;
`else
    logic unused_dec;
    assign unused_dec  = ^dec_data;
    assign o_mem_we    = 1'b0;
    assign o_mem_wdata = '0;
    assign o_mem_wpar  = '0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            last_q   <= '0;
            rdata_q  <= '0;
            rpar_q   <= '0;
            corr_q   <= '0;
            uncorr_q <= '0;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
`ifdef HAMMING_SCRUB_WRITEBACK_EN
            we_q     <= 1'b0;
            wdata_q  <= '0;
            wpar_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state_q != IDLE && i_abort) abort_q <= 1'b1;
            case (state_q)
                IDLE: if (i_start) begin
                    corr_q   <= '0;
                    uncorr_q <= '0;
                    addr_q   <= '0;
                    abort_q  <= 1'b0;
                    busy_q   <= 1'b1;
                    req_q    <= 1'b1;
                    state_q  <= RD_REQ;
                end
                RD_REQ: if (i_mem_gnt) begin
                    req_q   <= 1'b0;
                    state_q <= RD_WAIT;
                end
                RD_WAIT: if (i_mem_rvalid) begin
                    rdata_q <= i_mem_rdata;
                    rpar_q  <= i_mem_rpar;
                    state_q <= CHECK;
                end
                CHECK: begin
                    if (syn != '0) last_q <= addr_q;
                    if (is_corr_d) corr_q <= corr_cnt_d;
                    if (is_uncorr_d) uncorr_q <= uncorr_cnt_d;
                    state_q <= NEXT;
`ifdef HAMMING_SCRUB_WRITEBACK_EN
                    if (is_corr_d) begin
                        req_q   <= 1'b1;
                        we_q    <= 1'b1;
                        wdata_q <= dec_data;
                        wpar_q  <= rpar_q ^ par_fix_d;
                        state_q <= WR_REQ;
                    end
`endif
                end
`ifdef HAMMING_SCRUB_WRITEBACK_EN
                WR_REQ: if (i_mem_gnt) begin
                    req_q   <= 1'b0;
                    we_q    <= 1'b0;
                    state_q <= NEXT;
                end
`endif
                NEXT: if (addr_q == AW'(DEPTH - 1) || abort_q) begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end else begin
                    addr_q  <= addr_q + AW'(1);
                    req_q   <= 1'b1;
                    state_q <= RD_REQ;
                end
                DONE: begin
                    abort_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/hamming_scrub_ctrl.md
Name: hamming_scrub_ctrl

Overview:
- Background ECC scrubber that walks an ECC-protected memory from address 0 to DEPTH-1.
- For each word it reads data and parity, runs them through an internal hamming_dec instance (same DW/PW), classifies the syndrome and counts errors.
- Optionally writes corrected words back.
- Sits between a software/CSR trigger and one memory port; the memory-side arbiter grants it access via a req/gnt handshake.

Parameters:
DW, 8, data width per word
PW, 4, parity width; must satisfy 2^PW >= DW+PW+1
AW, 8, address width
DEPTH, 256, words to scrub (1..2^AW)
CW, 16, error counter width

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous active-high reset
i_start  input  1  one-cycle pulse; starts a pass when idle, ignored when busy
i_abort  input  1  stops the pass at the next word boundary
o_mem_req  output  1  memory access request
o_mem_we  output  1  1=write, 0=read; valid with o_mem_req
o_mem_addr  output  AW  access address
o_mem_wdata  output  DW  write data
o_mem_wpar  output  PW  write parity
i_mem_gnt  input  1  request accepted this cycle
i_mem_rvalid  input  1  read data valid, any cycles after the read grant
i_mem_rdata  input  DW  read data
i_mem_rpar  input  PW  read parity
o_busy  output  1  pass in progress
o_done  output  1  one-cycle pulse at end of pass (normal or aborted)
o_corr_cnt  output  CW  correctable errors this pass, saturating
o_uncorr_cnt  output  CW  uncorrectable syndromes this pass, saturating
o_last_err_addr  output  AW  address of the most recent nonzero syndrome

Behaviour:
- Reset (i_rst=1 at clock edge): state IDLE; all outputs 0; counters 0; address 0. Reset mid-pass abandons the pass with no o_done.
- Handshake: o_mem_req and the address/we/wdata/wpar outputs are held stable until the cycle with i_mem_gnt=1. req drops the cycle after the grant. Only one access is outstanding at a time.
- States:
  - IDLE: on i_start, clear both counters, addr=0, go RD_REQ; o_busy=1 from the next cycle.
  - RD_REQ: o_mem_req=1, we=0. On gnt, go RD_WAIT.
  - RD_WAIT: on i_mem_rvalid, register rdata/rpar, go CHECK.
  - CHECK: one cycle; compute syndrome s (the decoder's o_err_pos).
    - s==0: clean.
    - s is a data position <= DW+PW, not a power of two: correctable data error; corrected data comes from the decoder.
    - s is a power of two 2^k with k<PW: correctable parity error; corrected parity = rpar ^ (1<<k).
    - s > DW+PW: uncorrectable; increment o_uncorr_cnt.
    - Any nonzero s updates o_last_err_addr.
    - Correctable cases increment o_corr_cnt and go WR_REQ (writeback enabled) or NEXT.
  - WR_REQ: o_mem_req=1, we=1, same address, corrected data/parity. On gnt, go NEXT.
  - NEXT: if addr==DEPTH-1 or abort is pending, go DONE; else addr+1 and go RD_REQ.
  - DONE: o_done=1 for one cycle, o_busy=0, go IDLE. Counters and o_last_err_addr hold until the next start.
- Abort: i_abort is latched as pending in any non-IDLE state. It is acted on only in NEXT, so an in-flight read/write always completes. Abort in IDLE has no effect.
- Counters saturate at 2^CW-1 and do not wrap.
- i_start while busy is ignored. i_start and i_abort together in IDLE: the pass starts and the pending abort is cleared.
- Latency per clean word with zero-wait memory: RD_REQ(1) + RD_WAIT(>=1) + CHECK(1) + NEXT(1).

Optional Feature:
- Macro: HAMMING_SCRUB_WRITEBACK_EN.
- Defined: correctable words are written back as in WR_REQ.
- Undefined: detect-and-count only. WR_REQ is never entered, o_mem_we is tied 0, o_mem_wdata and o_mem_wpar are tied 0. Counters and o_last_err_addr behave identically.

Test Plan:
- Clean memory, DEPTH=4, gnt and rvalid same/next cycle: start -> 4 reads at addr 0..3, no writes, o_done after the last NEXT, counts 0/0.
- Addr 2 data bit 0 flipped (DW=8: syndrome 3): o_corr_cnt=1, o_last_err_addr=2, with WRITEBACK_EN a write to addr 2 with the original data and parity.
- Addr 1 parity bit 2 flipped (syndrome 4): o_corr_cnt=1, write of the unchanged data with parity bit 2 restored; data is not modified.
- Syndrome 15 injected at addr 3 (DW=8, PW=4): o_uncorr_cnt=1, no write, o_last_err_addr=3.
- i_abort while in RD_WAIT at addr 1, gnt delayed 3 cycles: read completes, no access to addr 2, o_done pulses once, o_busy=0.
- i_rst asserted in WR_REQ: next cycle req=0, busy=0, counters 0, no o_done. A new start works normally. i_start pulsed while busy is ignored.
